// File: rtl/timer_datapath.sv
// timer_datapath: value register y and step counter s driven by per-cycle
// controller commands. Status flags go back to the controller and registered
// 7-segment digits show y and s.
module timer_datapath #(
  parameter int W_Y    = 4,
  parameter int W_S    = 4,
  parameter int Y_MOD  = 10,
  parameter int S_MOD  = 10,
  parameter int S_LOAD = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W_Y-1:0] x,
  input  logic           y_en,
  input  logic           y_store_x,
  input  logic [1:0]     y_select_next,
  input  logic           s_en,
  input  logic           s_zero,
  input  logic           s_add,
  input  logic [1:0]     s_step,
  input  logic           disp_en,
  output logic [W_Y-1:0] y,
  output logic [W_S-1:0] s,
  output logic           s_wrap,
  output logic           s_is_zero,
  output logic           y_is_zero,
  output logic [6:0]     seg_y,
  output logic [6:0]     seg_s
);

  // Moduli are held one bit wider so that a modulus of exactly 2**W compares correctly.
  localparam logic [W_Y:0]   Y_MOD_X  = (W_Y+1)'(Y_MOD);
  localparam logic [W_Y-1:0] Y_MAX    = W_Y'(Y_MOD - 1);
  localparam logic [W_S:0]   S_MOD_X  = (W_S+1)'(S_MOD);
  localparam logic [W_S-1:0] S_LOAD_V = W_S'(S_LOAD);

  // Active-high segments {g..a}; anything above 9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [31:0] v);
    logic [6:0] seg;
    case (v)
      32'd0:   seg = 7'h3F;
      32'd1:   seg = 7'h06;
      32'd2:   seg = 7'h5B;
      32'd3:   seg = 7'h4F;
      32'd4:   seg = 7'h66;
      32'd5:   seg = 7'h6D;
      32'd6:   seg = 7'h7D;
      32'd7:   seg = 7'h07;
      32'd8:   seg = 7'h7F;
      32'd9:   seg = 7'h6F;
      default: seg = 7'h40;
    endcase
    return seg;
  endfunction

  logic [W_S:0]   s_sum;
  logic [W_S:0]   s_sum_wrapped;
  logic [W_S-1:0] s_next;
  logic [W_Y-1:0] y_next;
  logic [W_Y-1:0] y_inc;
  logic [W_Y-1:0] y_dec;
  logic           wrap_now;

  // Next value of s and the same-cycle wrap indication used by the y cascade.
  always_comb begin
    s_sum         = {1'b0, s} + (W_S+1)'(s_step);
    s_sum_wrapped = s_sum - S_MOD_X;
    s_next        = s;
    wrap_now      = 1'b0;
    if (!s_en) begin
      s_next = s;
    end else if (s_zero) begin
      s_next = S_LOAD_V;
    end else if (s_add) begin
      if (s_sum >= S_MOD_X) begin
        s_next   = s_sum_wrapped[W_S-1:0];
        wrap_now = 1'b1;
      end else begin
        s_next = s_sum[W_S-1:0];
      end
    end else begin
      if (s >= W_S'(s_step)) begin
        s_next = s - W_S'(s_step);
      end else begin
        s_next = {W_S{1'b0}};
      end
    end
  end

  // Next value of y; select 3 advances y only when s wraps on this same edge.
  always_comb begin
    y_inc  = (y == Y_MAX) ? {W_Y{1'b0}} : y + W_Y'(1);
    y_dec  = (y == {W_Y{1'b0}}) ? Y_MAX : y - W_Y'(1);
    y_next = y;
    if (!y_en) begin
      y_next = y;
    end else if (y_store_x) begin
      if ({1'b0, x} >= Y_MOD_X) begin
        y_next = Y_MAX;
      end else begin
        y_next = x;
      end
    end else begin
      case (y_select_next)
        2'd0:    y_next = y;
        2'd1:    y_next = y_inc;
        2'd2:    y_next = y_dec;
        2'd3:    y_next = wrap_now ? y_inc : y;
        default: y_next = y;
      endcase
    end
  end

  // State and display registers; digits decode the next state so they never lag y/s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y      <= {W_Y{1'b0}};
      s      <= {W_S{1'b0}};
      s_wrap <= 1'b0;
      seg_y  <= 7'h00;
      seg_s  <= 7'h00;
    end else begin
      y      <= y_next;
      s      <= s_next;
      s_wrap <= wrap_now;
      seg_y  <= disp_en ? seg_decode(32'(y_next)) : 7'h00;
      seg_s  <= disp_en ? seg_decode(32'(s_next)) : 7'h00;
    end
  end

  assign s_is_zero = (s == {W_S{1'b0}});
  assign y_is_zero = (y == {W_Y{1'b0}});

endmodule

// File: tb/tb_timer_datapath.sv
// Scoreboard bench for timer_datapath: a behavioural model predicts each edge,
// the prediction is queued when stimulus is driven and compared after the edge.
// A second instance with Y_MOD=16 covers the dash display of y.
module tb_timer_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] x;
  logic       y_en, y_store_x, s_en, s_zero, s_add, disp_en;
  logic [1:0] y_select_next, s_step;
  logic [3:0] y, s, y16, s16;
  logic       s_wrap, s_is_zero, y_is_zero, s_wrap16, s_is_zero16, y_is_zero16;
  logic [6:0] seg_y, seg_s, seg_y16, seg_s16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int y; int s; int wrap; int segy; int segs; int y16; int segy16;
  } exp_t;
  exp_t sbq[$];

  // model state
  int my, ms, mwrap, msegy, msegs, my16, msegy16;

  always #5 clk = ~clk;

  timer_datapath dut (
    .clk(clk), .rst(rst), .x(x), .y_en(y_en), .y_store_x(y_store_x),
    .y_select_next(y_select_next), .s_en(s_en), .s_zero(s_zero), .s_add(s_add),
    .s_step(s_step), .disp_en(disp_en), .y(y), .s(s), .s_wrap(s_wrap),
    .s_is_zero(s_is_zero), .y_is_zero(y_is_zero), .seg_y(seg_y), .seg_s(seg_s)
  );

  timer_datapath #(.Y_MOD(16)) dut16 (
    .clk(clk), .rst(rst), .x(x), .y_en(y_en), .y_store_x(y_store_x),
    .y_select_next(y_select_next), .s_en(s_en), .s_zero(s_zero), .s_add(s_add),
    .s_step(s_step), .disp_en(disp_en), .y(y16), .s(s16), .s_wrap(s_wrap16),
    .s_is_zero(s_is_zero16), .y_is_zero(y_is_zero16), .seg_y(seg_y16), .seg_s(seg_s16)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int digit(input int v, input bit en);
    int tbl [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
    if (!en) return 0;
    if (v > 9) return 'h40;
    return tbl[v];
  endfunction

  function automatic int y_model(input int yv, input int ymod, input bit wrap);
    int xv;
    if (!y_en) return yv;
    if (y_store_x) begin
      xv = int'(x);
      return (xv >= ymod) ? ymod - 1 : xv;
    end
    case (y_select_next)
      2'd1: return (yv + 1) % ymod;
      2'd2: return (yv + ymod - 1) % ymod;
      2'd3: return wrap ? (yv + 1) % ymod : yv;
      default: return yv;
    endcase
  endfunction

  task automatic set_cmd(input bit ye, input bit ysx, input int sel, input int xv,
                         input bit se, input bit sz, input bit sa, input int st);
    y_en = ye; y_store_x = ysx; y_select_next = 2'(sel); x = 4'(xv);
    s_en = se; s_zero = sz; s_add = sa; s_step = 2'(st);
  endtask

  task automatic model_reset();
    my = 0; ms = 0; mwrap = 0; msegy = 0; msegs = 0; my16 = 0; msegy16 = 0;
  endtask

  // Predict the next edge, queue it, clock, then pop and compare.
  task automatic cycle(input string tag);
    exp_t e;
    int sum;
    bit w;
    w = 1'b0;
    if (s_en) begin
      if (s_zero) ms = 6;
      else if (s_add) begin
        sum = ms + int'(s_step);
        if (sum >= 10) begin ms = sum - 10; w = 1'b1; end
        else ms = sum;
      end else ms = (ms - int'(s_step) < 0) ? 0 : ms - int'(s_step);
    end
    my   = y_model(my, 10, w);
    my16 = y_model(my16, 16, w);
    e.y = my; e.s = ms; e.wrap = int'(w); e.y16 = my16;
    e.segy = digit(my, disp_en); e.segs = digit(ms, disp_en); e.segy16 = digit(my16, disp_en);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      check({tag, " queue"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      check({tag, " y"}, int'(y), e.y);
      check({tag, " s"}, int'(s), e.s);
      check({tag, " s_wrap"}, int'(s_wrap), e.wrap);
      check({tag, " seg_y"}, int'(seg_y), e.segy);
      check({tag, " seg_s"}, int'(seg_s), e.segs);
      check({tag, " s_is_zero"}, int'(s_is_zero), int'(e.s == 0));
      check({tag, " y_is_zero"}, int'(y_is_zero), int'(e.y == 0));
      check({tag, " y16"}, int'(y16), e.y16);
      check({tag, " seg_y16"}, int'(seg_y16), e.segy16);
    end
  endtask

  initial begin
    rst = 1'b1; disp_en = 1'b1;
    set_cmd(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset y", int'(y), 0);
    check("reset s", int'(s), 0);
    check("reset s_wrap", int'(s_wrap), 0);
    check("reset seg_y", int'(seg_y), 0);
    check("reset seg_s", int'(seg_s), 0);
    rst = 1'b0;

    // s load then saturating decrement by 2
    set_cmd(0, 0, 0, 0, 1, 1, 0, 0); cycle("load6");
    set_cmd(0, 0, 0, 0, 1, 0, 0, 2);
    for (int i = 0; i < 4; i++) cycle("dec2");

    // y saturating store, increment and decrement wrap, hold when disabled
    set_cmd(1, 1, 0, 12, 0, 0, 0, 0); cycle("store12");
    set_cmd(1, 0, 1, 0, 0, 0, 0, 0);  cycle("ysel1");
    set_cmd(1, 0, 2, 0, 0, 0, 0, 0);  cycle("ysel2");
    set_cmd(0, 0, 1, 0, 0, 0, 0, 0);  cycle("yhold");

    // s=8, y=4, then wrapping add cascades into y on the same edge
    set_cmd(1, 1, 0, 4, 1, 1, 0, 0); cycle("prep_a");
    set_cmd(0, 0, 0, 0, 1, 0, 1, 2); cycle("prep_b");
    set_cmd(1, 0, 3, 0, 1, 0, 1, 3); cycle("cascade");
    set_cmd(0, 0, 0, 0, 0, 0, 0, 0); cycle("wrap_drop");

    // s=4, non-wrapping add with cascade select, then zero step
    set_cmd(0, 0, 0, 0, 1, 1, 0, 0); cycle("prep_c");
    set_cmd(0, 0, 0, 0, 1, 0, 0, 2); cycle("prep_d");
    set_cmd(1, 0, 3, 0, 1, 0, 1, 1); cycle("nowrap");
    set_cmd(1, 0, 3, 0, 1, 0, 1, 0); cycle("step0");

    // display: y=7, s=6; x=15 dash on Y_MOD=16 instance; blanking
    set_cmd(1, 1, 0, 7, 1, 1, 0, 0); cycle("disp76");
    set_cmd(1, 1, 0, 15, 0, 0, 0, 0); cycle("disp15");
    disp_en = 1'b0;
    set_cmd(0, 0, 0, 0, 0, 0, 0, 0); cycle("blank");
    disp_en = 1'b1;

    // randomized command mix
    for (int i = 0; i < 60; i++) begin
      set_cmd(1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 3),
              $urandom_range(0, 15), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 7) == 0), 1'($urandom), $urandom_range(0, 3));
      disp_en = 1'($urandom_range(0, 5) != 0);
      cycle("rand");
    end

    // async reset mid-count at y=5, s=7
    disp_en = 1'b1;
    set_cmd(1, 1, 0, 5, 1, 1, 0, 0); cycle("pre_rst_a");
    set_cmd(0, 0, 0, 0, 1, 0, 1, 1); cycle("pre_rst_b");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst y", int'(y), 0);
    check("arst s", int'(s), 0);
    check("arst s_wrap", int'(s_wrap), 0);
    check("arst seg_y", int'(seg_y), 0);
    check("arst seg_s", int'(seg_s), 0);
    check("arst seg_y16", int'(seg_y16), 0);
    #1;
    rst = 1'b0;
    set_cmd(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
